// File: rtl/shutdown_seq.sv
// shutdown_seq: orderly shutdown responder for the main logic domain.
// Takes the power controller's one-cycle trigger, asks the datapath to quiesce,
// waits for acknowledgement or a timeout, settles, then pulses main_done.
// Optional feature macro: SHUTDOWN_ABORT_EN (a second trigger during DRAIN aborts).
module shutdown_seq #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    // c_ms(500): drain timeout in cycles
    parameter int unsigned TMO_CMAX  = CLK_HZ / 1000 * 500,
    // c_ms(20): settle time in cycles
    parameter int unsigned HOLD_CMAX = CLK_HZ / 1000 * 20
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tr_pwr_i,
    input  logic       busy_i,
    input  logic       ack_idle_i,
    output logic       req_idle_o,
    output logic       lock_o,
    output logic       main_done_o,
    output logic       led_sd_o,
    output logic       timed_out_o,
    output logic [2:0] state_o
);

    localparam int unsigned CMax = (TMO_CMAX > HOLD_CMAX) ? TMO_CMAX : HOLD_CMAX;
    localparam int unsigned CntW = $clog2(CMax) + 1;
    localparam logic [CntW-1:0] TmoLast  = CntW'(TMO_CMAX - 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CMAX - 1);

    typedef enum logic [2:0] {
        StRun   = 3'd0,
        StDrain = 3'd1,
        StHold  = 3'd2,
        StDone  = 3'd3,
        StPark  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            req_idle_q, req_idle_d;
    logic            lock_q, lock_d;
    logic            main_done_q, main_done_d;
    logic            led_sd_q, led_sd_d;
    logic            timed_out_q, timed_out_d;

    // Next state, shared counter and sticky timeout flag.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timed_out_d = timed_out_q;
        unique case (state_q)
            StRun: begin
                if (tr_pwr_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
`ifdef SHUTDOWN_ABORT_EN
                if (tr_pwr_i) begin
                    state_d = StRun;
                end else
`endif
                if (ack_idle_i && !busy_i) begin
                    // Acknowledge beats a simultaneous timeout.
                    state_d = StHold;
                end else if (cnt_q == TmoLast) begin
                    state_d     = StHold;
                    timed_out_d = 1'b1;
                end else if (cnt_q < TmoLast) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == HoldLast) begin
                    state_d = StDone;
                end else if (cnt_q < HoldLast) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StPark;
            end
            StPark: begin
                state_d = StPark;
            end
            default: begin
                state_d = StRun;
            end
        endcase
        // Every state entry starts the counter from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_comb begin
        req_idle_d  = 1'b0;
        led_sd_d    = 1'b0;
        lock_d      = 1'b0;
        main_done_d = (state_q == StDone);
        unique case (state_d)
            StRun: begin
                lock_d = busy_i;
            end
            StDrain: begin
                req_idle_d = 1'b1;
                led_sd_d   = 1'b1;
`ifdef SHUTDOWN_ABORT_EN
                lock_d     = 1'b0;
`else
                lock_d     = 1'b1;
`endif
            end
            StHold, StDone: begin
                req_idle_d = 1'b1;
                led_sd_d   = 1'b1;
                lock_d     = 1'b1;
            end
            StPark: begin
                req_idle_d = 1'b1;
                led_sd_d   = 1'b1;
                lock_d     = 1'b0;
            end
            default: begin
                lock_d = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; reset wins immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StRun;
            cnt_q       <= '0;
            req_idle_q  <= 1'b0;
            lock_q      <= 1'b0;
            main_done_q <= 1'b0;
            led_sd_q    <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_idle_q  <= req_idle_d;
            lock_q      <= lock_d;
            main_done_q <= main_done_d;
            led_sd_q    <= led_sd_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign req_idle_o  = req_idle_q;
    assign lock_o      = lock_q;
    assign main_done_o = main_done_q;
    assign led_sd_o    = led_sd_q;
    assign timed_out_o = timed_out_q;
    assign state_o     = state_q;

endmodule
